prio_enc_rr: RTL and testbench
==============================

Name: prio_enc_rr

Overview:
- Registered N-input priority encoder with request latching, selectable fixed or round-robin priority, and a valid/ready output handshake.
- Successor to the legacy combinational 8-to-3 encoder. Parametrised in width, and able to hold multiple outstanding requests.
- Sits between interrupt/request sources and a single consumer that services one index at a time.

Parameters:
- N, 8, number of request lines; must be ≥2.
- IDX_W, 3, index width; must equal clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  N  request bits, sampled every cycle; any set bit is OR'd into pending
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- clr  input  1  synchronous clear of all pending requests
- out_valid  output  1  out_idx holds a granted index
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready
- out_idx  output  IDX_W  granted request index
- pend_cnt  output  IDX_W+1  number of set bits in pending (combinational from the register)

Behaviour:
- Reset state: pending=0, out_valid=0, out_idx=0, last=0. req is ignored in any cycle where rst=1.
- Output register load condition: load = !out_valid || out_ready.
- load && pending!=0:
  - out_idx <= sel
  - out_valid <= 1
  - last <= sel
  - sel's bit is removed from pending
- load && pending==0: out_valid <= 0; out_idx holds its value.
- !load: out_valid, out_idx and last are held stable; selection is stalled.
- Pending update: pending_next = (pending & ~grant_mask) | req.
  - A req bit equal to the bit granted in the same cycle stays set (req wins).
- Latency: req high in cycle t → pending bit set at edge t+1 → out_valid at edge t+2, provided the output register is free.
- Throughput: one grant per cycle while pending is non-zero and out_ready=1.
- Fixed mode: sel = highest set index in pending. This matches the legacy encoder (bit 7 beats bit 0).
- Round-robin mode: descending search starting at last-1, wrapping below 0 to N-1, ending at last.
  - With last=0 the search order is N-1..0, so the first grant after reset is the same in both modes.
  - A lone pending bit equal to last is granted.
- last updates on every grant in both modes. A mode change affects the next selection only; the current output is untouched.
- clr=1:
  - pending <= 0, and that cycle's req is discarded.
  - The output register is unaffected: a valid index stays until accepted.
  - The selection in the clr cycle still occurs if load is true.
- clr and rst together: rst dominates; the resulting state is identical.
- pend_cnt range is 0..N; at N it is exactly representable in IDX_W+1 bits.
- Width rule: all index arithmetic is modulo N. For non-power-of-two N, the wrap from 0 goes to N-1, never to 2^IDX_W-1.
- No combinational path from req to outputs. out_valid does not depend combinationally on out_ready.

Decomposition:
- Package pe_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, and a clog2 helper function.
- Sub-module prio_sel (combinational): N-bit input, outputs highest set index plus a found flag.
- Round-robin is built by instantiating prio_sel twice:
  - on pending masked to indices < last;
  - on unmasked pending.
  - Use the masked result if found, otherwise the unmasked one.

Test Plan:
1. Fixed mode, out_ready=1, req=8'b1001_0010 for one cycle → out_idx 7, 4, 1 on three consecutive cycles starting 2 cycles later, then out_valid=0; pend_cnt goes 3, 2, 1, 0.
2. Backpressure: as test 1 with out_ready=0 for 5 cycles → out_idx=7 held with out_valid=1 and pend_cnt=2. Release → 4, 1 follow back-to-back.
3. req=8'hFF held constantly, out_ready=1:
   - mode=0 → out_idx=7 every cycle.
   - mode=1 → 7, 6, 5, 4, 3, 2, 1, 0, 7, …
4. Fixed mode, req=8'h08 held every cycle → out_idx=3 with out_valid continuously high from cycle 2; pend_cnt stays 1.
5. req=8'h0F, then out_ready=0 with out_valid showing 3, then clr pulse → pend_cnt=0 next cycle. Index 3 remains until accepted, then out_valid=0.
6. rst asserted mid-stream with req=8'hFF during the rst cycle → next cycle out_valid=0, pend_cnt=0, out_idx=0. First RR grant after reset is 7.

Source files
------------

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the registered priority encoder (prio_enc_rr) and
//   its combinational selector (prio_sel).
//
//   Contents:
//     MODE_FIXED / MODE_RR : encodings of the prio_enc_rr 'mode' input
//     clog2()              : ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package pe_pkg;

  // Priority mode selector values.
  localparam logic MODE_FIXED = 1'b0;  // highest pending index always wins
  localparam logic MODE_RR    = 1'b1;  // rotate downwards from the last grant

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : pe_pkg

// File: rtl/prio_sel.sv
// ---------------------------------------------------------------------------
// prio_sel
//   Purely combinational "highest set bit" finder.
//
//   Parameters:
//     N      : width of the input vector
//     IDX_W  : width of the returned index
//
//   Ports:
//     vec    in  [N-1:0]      candidate bits
//     idx    out [IDX_W-1:0]  index of the highest set bit (0 when none set)
//     found  out              at least one bit of vec is set
// ---------------------------------------------------------------------------
module prio_sel
  import pe_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Ascending scan: every later (higher) set bit overwrites the earlier one,
  // so the final value is the highest set index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule : prio_sel

// File: rtl/prio_enc_rr.sv
// ---------------------------------------------------------------------------
// prio_enc_rr
//   Registered N-input priority encoder. Incoming request bits are OR'd into
//   a pending register; one pending index is granted per cycle into an output
//   register that follows a valid/ready handshake. Priority is either fixed
//   (highest index wins) or round-robin (descending search starting just
//   below the previous grant, wrapping modulo N).
//
//   Parameters:
//     N      : number of request lines (>= 2)
//     IDX_W  : index width, must equal clog2(N)
//
//   Ports:
//     clk        in                rising-edge clock
//     rst        in                synchronous active-high reset
//     req        in  [N-1:0]       request bits, OR'd into pending each cycle
//     mode       in                MODE_FIXED or MODE_RR
//     clr        in                synchronous clear of all pending requests
//     out_valid  out               out_idx holds a granted index
//     out_ready  in                consumer accepts when out_valid && out_ready
//     out_idx    out [IDX_W-1:0]   granted request index
//     pend_cnt   out [IDX_W:0]     population count of the pending register
// ---------------------------------------------------------------------------
module prio_enc_rr
  import pe_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   pend_cnt
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // -------------------------------------------------------------------------
  if (N < 2) begin : g_bad_n
    $error("prio_enc_rr: N must be at least 2");
  end
  if (IDX_W != clog2(N)) begin : g_bad_idx_w
    $error("prio_enc_rr: IDX_W must equal clog2(N)");
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [N-1:0]     pending_reg;
  logic [N-1:0]     pending_next;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_idx_reg;
  logic [IDX_W-1:0] last_reg;

  // -------------------------------------------------------------------------
  // Selection
  // -------------------------------------------------------------------------
  logic [N-1:0]     low_mask;      // indices strictly below last_reg
  logic [N-1:0]     pending_low;
  logic [IDX_W-1:0] low_idx;
  logic             low_found;
  logic [IDX_W-1:0] full_idx;
  logic             full_found;
  logic [IDX_W-1:0] sel_idx;
  logic             load;
  logic             grant;
  logic [N-1:0]     grant_mask;

  // Every index below N fits in IDX_W bits, so the compare is exact and the
  // mask never references a nonexistent index for non-power-of-two N.
  for (genvar gi = 0; gi < N; gi++) begin : g_low_mask
    assign low_mask[gi] = (IDX_W'(gi) < last_reg);
  end

  assign pending_low = pending_reg & low_mask;

  // Round-robin search order is last-1 down to 0, then N-1 down to last.
  // The first half is the highest bit below last; if none exists, the
  // highest bit overall is exactly the second half (it also covers a lone
  // pending bit equal to last).
  prio_sel #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_sel_low (
    .vec   (pending_low),
    .idx   (low_idx),
    .found (low_found)
  );

  prio_sel #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_sel_full (
    .vec   (pending_reg),
    .idx   (full_idx),
    .found (full_found)
  );

  always_comb begin
    sel_idx = full_idx;
    if (mode == MODE_RR && low_found) begin
      sel_idx = low_idx;
    end
  end

  // The output register accepts a new value when empty or being drained.
  // Only registered state feeds out_valid, so out_ready never reaches it
  // combinationally.
  assign load  = !out_valid_reg || out_ready;
  assign grant = load && full_found;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant_mask
    assign grant_mask[gi] = grant && (sel_idx == IDX_W'(gi));
  end

  // OR-ing req after the grant removal lets a request re-arm the bit that
  // is granted in the same cycle. clr discards both pending and req.
  always_comb begin
    pending_next = (pending_reg & ~grant_mask) | req;
    if (clr) begin
      pending_next = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      last_reg      <= '0;
    end else begin
      pending_reg <= pending_next;
      if (load) begin
        out_valid_reg <= full_found;
        if (full_found) begin
          out_idx_reg <= sel_idx;
          last_reg    <= sel_idx;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending population count (reaches N, hence the extra bit)
  // -------------------------------------------------------------------------
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pend_cnt = pend_cnt + (IDX_W + 1)'(pending_reg[i]);
    end
  end

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;

endmodule : prio_enc_rr

// File: tb/tb_prio_enc_rr.sv
module tb_prio_enc_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [3:0] pend_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prio_enc_rr #(
    .N     (8),
    .IDX_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .mode      (mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pend_cnt  (pend_cnt)
  );

  // Advance one clock; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req       = '0;
    clr       = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reset state, with clr and req asserted alongside rst.
  task automatic test_reset();
    rst       = 1'b1;
    clr       = 1'b1;
    req       = 8'hFF;
    mode      = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      $display("[TB] reset cyc %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      tests++;
      if (out_idx !== 3'd0) begin fails++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
      tests++;
      if (pend_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", pend_cnt); end
    end
    rst = 1'b0;
    clr = 1'b0;
    req = '0;
  endtask

  // Single-cycle burst in fixed mode, consumer always ready.
  task automatic test_fixed_burst();
    logic [2:0] e_idx [3];
    logic [3:0] e_cnt [3];
    e_idx = '{3'd7, 3'd4, 3'd1};
    e_cnt = '{4'd2, 4'd1, 4'd0};
    do_reset();
    req = 8'b1001_0010;
    tick();
    req = '0;
    $display("[TB] burst latch: valid=%0b cnt=%0d", out_valid, pend_cnt);
    tests++;
    if (out_valid !== 1'b0 || pend_cnt !== 4'd3) begin
      fails++; $display("FAIL burst_latch: valid=%0b cnt=%0d want valid=0 cnt=3", out_valid, pend_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("[TB] burst grant %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== e_idx[k] || pend_cnt !== e_cnt[k]) begin
        fails++;
        $display("FAIL burst_grant%0d: valid=%0b idx=%0d cnt=%0d want valid=1 idx=%0d cnt=%0d",
                 k, out_valid, out_idx, pend_cnt, e_idx[k], e_cnt[k]);
      end
    end
    tick();
    $display("[TB] burst drained: valid=%0b", out_valid);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL burst_drained: valid=%0b want 0", out_valid); end
  endtask

  // Same burst with the consumer stalled for five cycles.
  task automatic test_backpressure();
    logic [2:0] e_idx [2];
    logic [3:0] e_cnt [2];
    e_idx = '{3'd4, 3'd1};
    e_cnt = '{4'd1, 4'd0};
    do_reset();
    out_ready = 1'b0;
    req = 8'b1001_0010;
    tick();
    req = '0;
    tick();
    for (int k = 0; k < 5; k++) begin
      $display("[TB] stall cyc %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7 || pend_cnt !== 4'd2) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%0b idx=%0d cnt=%0d want valid=1 idx=7 cnt=2",
                 k, out_valid, out_idx, pend_cnt);
      end
      if (k < 4) tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      $display("[TB] release grant %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== e_idx[k] || pend_cnt !== e_cnt[k]) begin
        fails++;
        $display("FAIL release_grant%0d: valid=%0b idx=%0d cnt=%0d want valid=1 idx=%0d cnt=%0d",
                 k, out_valid, out_idx, pend_cnt, e_idx[k], e_cnt[k]);
      end
    end
  endtask

  // All requests held: fixed mode always grants 7, RR rotates downwards.
  task automatic test_all_req();
    logic [2:0] e_rr [10];
    e_rr = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    do_reset();
    req = 8'hFF;
    tick();
    $display("[TB] all_req latch: cnt=%0d", pend_cnt);
    tests++;
    if (pend_cnt !== 4'd8) begin fails++; $display("FAIL all_req_cnt_full: got %0d want 8", pend_cnt); end
    for (int k = 0; k < 5; k++) begin
      tick();
      $display("[TB] fixed all_req %0d: valid=%0b idx=%0d", k, out_valid, out_idx);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
        fails++; $display("FAIL fixed_all%0d: valid=%0b idx=%0d want valid=1 idx=7", k, out_valid, out_idx);
      end
    end
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      $display("[TB] rr all_req %0d: valid=%0b idx=%0d", k, out_valid, out_idx);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== e_rr[k]) begin
        fails++; $display("FAIL rr_all%0d: valid=%0b idx=%0d want valid=1 idx=%0d", k, out_valid, out_idx, e_rr[k]);
      end
    end
    req = '0;
  endtask

  // A single request held: req re-arms the bit granted in the same cycle.
  task automatic test_back_to_back();
    do_reset();
    req = 8'h08;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      $display("[TB] b2b %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend_cnt !== 4'd1) begin
        fails++;
        $display("FAIL b2b%0d: valid=%0b idx=%0d cnt=%0d want valid=1 idx=3 cnt=1", k, out_valid, out_idx, pend_cnt);
      end
    end
    req = '0;
  endtask

  // clr empties pending but leaves the output register alone.
  task automatic test_clr();
    do_reset();
    out_ready = 1'b0;
    req = 8'h0F;
    tick();
    req = '0;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend_cnt !== 4'd3) begin
      fails++;
      $display("FAIL clr_pre: valid=%0b idx=%0d cnt=%0d want valid=1 idx=3 cnt=3", out_valid, out_idx, pend_cnt);
    end
    clr = 1'b1;
    req = 8'hF0;
    tick();
    clr = 1'b0;
    req = '0;
    for (int k = 0; k < 2; k++) begin
      $display("[TB] clr hold %0d: valid=%0b idx=%0d cnt=%0d", k, out_valid, out_idx, pend_cnt);
      tests++;
      if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend_cnt !== 4'd0) begin
        fails++;
        $display("FAIL clr_hold%0d: valid=%0b idx=%0d cnt=%0d want valid=1 idx=3 cnt=0", k, out_valid, out_idx, pend_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    $display("[TB] clr accepted: valid=%0b idx=%0d", out_valid, out_idx);
    tests++;
    if (out_valid !== 1'b0 || out_idx !== 3'd3) begin
      fails++; $display("FAIL clr_accept: valid=%0b idx=%0d want valid=0 idx=3", out_valid, out_idx);
    end
    // Selection still happens in the clr cycle when the output is free.
    req = 8'h0F;
    tick();
    req = '0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    $display("[TB] clr with load: valid=%0b idx=%0d cnt=%0d", out_valid, out_idx, pend_cnt);
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd3 || pend_cnt !== 4'd0) begin
      fails++;
      $display("FAIL clr_load: valid=%0b idx=%0d cnt=%0d want valid=1 idx=3 cnt=0", out_valid, out_idx, pend_cnt);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL clr_load_empty: valid=%0b want 0", out_valid); end
  endtask

  // Reset in the middle of RR traffic, then RR restarts from index 7.
  task automatic test_mid_reset();
    do_reset();
    mode = 1'b1;
    req  = 8'hFF;
    tick();
    tick();
    tick();
    tests++;
    if (out_idx !== 3'd6) begin fails++; $display("FAIL midrst_pre: idx=%0d want 6", out_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("[TB] mid reset: valid=%0b idx=%0d cnt=%0d", out_valid, out_idx, pend_cnt);
    tests++;
    if (out_valid !== 1'b0 || out_idx !== 3'd0 || pend_cnt !== 4'd0) begin
      fails++;
      $display("FAIL midrst_state: valid=%0b idx=%0d cnt=%0d want valid=0 idx=0 cnt=0", out_valid, out_idx, pend_cnt);
    end
    tick();
    req = '0;
    tick();
    $display("[TB] post reset rr grant: valid=%0b idx=%0d", out_valid, out_idx);
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7) begin
      fails++; $display("FAIL midrst_first: valid=%0b idx=%0d want valid=1 idx=7", out_valid, out_idx);
    end
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_idx !== 3'd6) begin
      fails++; $display("FAIL midrst_second: valid=%0b idx=%0d want valid=1 idx=6", out_valid, out_idx);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    mode      = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    #1;
    test_reset();
    test_fixed_burst();
    test_backpressure();
    test_all_req();
    test_back_to_back();
    test_clr();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_prio_enc_rr
